// File: rtl/invaders_pkg.sv
// invaders_pkg
//   Definitions shared by the alien-formation producer (invader_march_ctrl)
//   and consumer (Machine): march FSM state encoding, the screen-edge
//   positions and the bus widths of the move interface.
package invaders_pkg;

   localparam int unsigned POS_W    = 11;  // formation x position width
   localparam int unsigned ALIVE_W  = 6;   // alive invader count width
   localparam int unsigned PERIOD_W = 24;  // step period / counter width

   localparam logic [POS_W-1:0] SCREEN_X_MIN = 11'd16;
   localparam logic [POS_W-1:0] SCREEN_X_MAX = 11'd560;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_TICK  = 2'd2
   } march_state_t;

endpackage

// File: rtl/step_period_calc.sv
// step_period_calc
//   Combinational step period: P = MIN_PERIOD + alive_count * PERIOD_STEP,
//   evaluated wide enough that it cannot overflow, then clamped to the
//   largest PERIOD_W-bit value.
// Ports:
//   i_alive_count  in   ALIVE_W   invaders still alive
//   o_period       out  PERIOD_W  clocks per step (saturated)
module step_period_calc
   import invaders_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 24'd400000,
   parameter logic [PERIOD_W-1:0] PERIOD_STEP = 24'd40000
)(
   input  logic [ALIVE_W-1:0]  i_alive_count,
   output logic [PERIOD_W-1:0] o_period
);

   localparam int unsigned FULL_W = PERIOD_W + ALIVE_W + 1;

   logic [FULL_W-1:0] w_full;

   assign w_full = FULL_W'(MIN_PERIOD)
                 + FULL_W'(i_alive_count) * FULL_W'(PERIOD_STEP);

   assign o_period = (w_full > FULL_W'({PERIOD_W{1'b1}})) ? '1
                                                          : w_full[PERIOD_W-1:0];

endmodule

// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl
//   Producer side of the alien-formation move interface. Counts out one step
//   period, then either strobes mueva (normal step) or, when the formation
//   sits at the screen edge in the march direction, strobes drop and reverses
//   dir. The period shrinks as invaders are destroyed.
// Ports:
//   CLK          in   1        system clock, rising edge
//   RST          in   1        synchronous active-high reset
//   enable       in   1        game running; 0 pauses marching
//   alive_count  in   ALIVE_W  invaders still alive
//   posx         in   POS_W    formation x position from Machine
//   mueva        out  1        one-cycle step strobe
//   dir          out  1        march direction, 1 = right
//   drop         out  1        one-cycle row-drop request
//   halted       out  1        wave cleared (alive_count == 0), 1 cycle late
module invader_march_ctrl
   import invaders_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 24'd400000,
   parameter logic [PERIOD_W-1:0] PERIOD_STEP = 24'd40000,
   parameter logic [POS_W-1:0]    X_MIN       = SCREEN_X_MIN,
   parameter logic [POS_W-1:0]    X_MAX       = SCREEN_X_MAX
)(
   input  logic               CLK,
   input  logic               RST,
   input  logic               enable,
   input  logic [ALIVE_W-1:0] alive_count,
   input  logic [POS_W-1:0]   posx,
   output logic               mueva,
   output logic               dir,
   output logic               drop,
   output logic               halted
);

   localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

   march_state_t        r_state;
   march_state_t        w_state_nxt;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] w_cnt_nxt;
   logic                r_mueva;
   logic                r_drop;
   logic                r_dir;
   logic                r_halted;
   logic                w_mueva_nxt;
   logic                w_drop_nxt;
   logic                w_dir_nxt;
   logic [PERIOD_W-1:0] w_period;
   logic [PERIOD_W-1:0] w_reload;
   logic                w_run;
   logic                w_edge;

   step_period_calc #(
      .MIN_PERIOD  (MIN_PERIOD),
      .PERIOD_STEP (PERIOD_STEP)
   ) u_period (
      .i_alive_count (alive_count),
      .o_period      (w_period)
   );

   // Counter holds P-1 so that load + P-1 decrements + TICK spans P+1 clocks.
   assign w_reload = (w_period == '0) ? '0 : (w_period - CNT_ONE);
   assign w_run    = enable && (alive_count != '0);
   assign w_edge   = (r_dir && (posx >= X_MAX)) || (!r_dir && (posx <= X_MIN));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mueva_nxt = 1'b0;
      w_drop_nxt  = 1'b0;
      w_dir_nxt   = r_dir;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_run) begin
               w_cnt_nxt   = w_reload;
               w_state_nxt = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (!w_run) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_TICK;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_TICK: begin
            if (!w_run) begin
               // pending tick is discarded
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               if (w_edge) begin
                  w_drop_nxt = 1'b1;
                  w_dir_nxt  = ~r_dir;
               end else begin
                  w_mueva_nxt = 1'b1;
               end
               w_cnt_nxt   = w_reload;
               w_state_nxt = ST_COUNT;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_mueva  <= 1'b0;
         r_drop   <= 1'b0;
         r_dir    <= 1'b1;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mueva  <= w_mueva_nxt;
         r_drop   <= w_drop_nxt;
         r_dir    <= w_dir_nxt;
         r_halted <= (alive_count == '0);
      end
   end

   assign mueva  = r_mueva;
   assign drop   = r_drop;
   assign dir    = r_dir;
   assign halted = r_halted;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// tb_invader_march_ctrl
//   Bench for invader_march_ctrl. The reference model tracks the number of
//   clocks left until the next tick event and applies the edge/direction rule
//   at that event; it is compared against every DUT output each cycle.
module tb_invader_march_ctrl;
   import invaders_pkg::*;

   localparam logic [PERIOD_W-1:0] TB_MIN  = 24'd4;
   localparam logic [PERIOD_W-1:0] TB_STEP = 24'd2;
   localparam logic [POS_W-1:0]    TB_XMIN = 11'd10;
   localparam logic [POS_W-1:0]    TB_XMAX = 11'd100;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               enable = 1'b0;
   logic [ALIVE_W-1:0] alive_count = '0;
   logic [POS_W-1:0]   posx = 11'd50;
   logic               mueva, dir, drop, halted;

   logic [ALIVE_W-1:0]  sat_alive = '0;
   logic [PERIOD_W-1:0] sat_period;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_no = 0;
   int pulse_q[$];

   // reference model state
   bit m_run = 1'b0;
   int m_rem = 0;
   bit m_dir = 1'b1;
   bit m_mueva = 1'b0;
   bit m_drop = 1'b0;
   bit m_halted = 1'b0;

   invader_march_ctrl #(
      .MIN_PERIOD  (TB_MIN),
      .PERIOD_STEP (TB_STEP),
      .X_MIN       (TB_XMIN),
      .X_MAX       (TB_XMAX)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .enable      (enable),
      .alive_count (alive_count),
      .posx        (posx),
      .mueva       (mueva),
      .dir         (dir),
      .drop        (drop),
      .halted      (halted)
   );

   step_period_calc #(
      .MIN_PERIOD  (24'd4),
      .PERIOD_STEP (24'h800000)
   ) u_sat (
      .i_alive_count (sat_alive),
      .o_period      (sat_period)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
      end
   endtask

   function automatic int period_of(input int a);
      longint p;
      p = 64'd4 + 64'd2 * longint'(a);
      if (p > 64'hFFFFFF) p = 64'hFFFFFF;
      return int'(p);
   endfunction

   // One clock edge of the reference behaviour, using the inputs it sampled.
   task automatic model_edge();
      bit go;
      bit at_edge;
      if (RST) begin
         m_run = 1'b0; m_dir = 1'b1; m_mueva = 1'b0; m_drop = 1'b0; m_halted = 1'b0;
      end else begin
         m_mueva  = 1'b0;
         m_drop   = 1'b0;
         m_halted = (alive_count == 0);
         go = enable && (alive_count != 0);
         if (!m_run) begin
            if (go) begin
               m_run = 1'b1;
               m_rem = period_of(int'(alive_count)) + 1;
            end
         end else if (!go) begin
            m_run = 1'b0;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               at_edge = m_dir ? (int'(posx) >= 100) : (int'(posx) <= 10);
               if (at_edge) begin
                  m_drop = 1'b1;
                  m_dir  = !m_dir;
               end else begin
                  m_mueva = 1'b1;
               end
               m_rem = period_of(int'(alive_count)) + 1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      cyc_no++;
      #1;
      check("mueva",  32'(mueva),  32'(m_mueva));
      check("drop",   32'(drop),   32'(m_drop));
      check("dir",    32'(dir),    32'(m_dir));
      check("halted", 32'(halted), 32'(m_halted));
      if (mueva) pulse_q.push_back(cyc_no);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int k0;
      bit found;
      int r;

      // 1: reset, then steady marching with P = 10
      RST = 1'b1; enable = 1'b1; alive_count = 6'd3; posx = 11'd50;
      step();
      check("rst_mueva", 32'(mueva), 32'd0);
      check("rst_dir",   32'(dir),   32'd1);
      RST = 1'b0;
      pulse_q.delete();
      k0 = cyc_no + 1;
      run(40);
      check("s1_npulse", 32'(pulse_q.size()), 32'd3);
      if (pulse_q.size() >= 2) begin
         check("s1_first", 32'(pulse_q[0] - k0), 32'd11);
         check("s1_gap",   32'(pulse_q[1] - pulse_q[0]), 32'd11);
      end

      // 2: right edge -> drop and reverse, then normal step; then left edge
      posx = 11'd100;
      run(11);
      check("s2_dir_left", 32'(dir), 32'd0);
      posx = 11'd99;
      run(11);
      posx = 11'd5;
      run(12);
      posx = 11'd50;

      // 3: alive_count changes mid-period, wave cleared, then resumes
      run(4);
      alive_count = 6'd1;
      run(30);
      alive_count = 6'd0;
      run(15);
      check("s3_halted", 32'(halted), 32'd1);
      alive_count = 6'd2;
      pulse_q.delete();
      k0 = cyc_no + 1;
      run(20);
      if (pulse_q.size() >= 1) check("s3_resume", 32'(pulse_q[0] - k0), 32'd9);
      else                     check("s3_resume_seen", 32'd0, 32'd1);

      // 4: reset part-way through a count
      alive_count = 6'd3;
      run(5);
      RST = 1'b1;
      step();
      check("s4_dir", 32'(dir), 32'd1);
      RST = 1'b0;
      pulse_q.delete();
      k0 = cyc_no + 1;
      run(14);
      if (pulse_q.size() >= 1) check("s4_first", 32'(pulse_q[0] - k0), 32'd11);
      else                     check("s4_first_seen", 32'd0, 32'd1);

      // 5: enable dropped one cycle before a due tick
      pulse_q.delete();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = (pulse_q.size() != 0);
      end
      check("s5_found", 32'(found), 32'd1);
      pulse_q.delete();
      run(9);
      enable = 1'b0;
      run(3);
      check("s5_no_pulse", 32'(pulse_q.size()), 32'd0);
      enable = 1'b1;
      k0 = cyc_no + 1;
      run(14);
      if (pulse_q.size() >= 1) check("s5_restart", 32'(pulse_q[0] - k0), 32'd11);
      else                     check("s5_restart_seen", 32'd0, 32'd1);

      // 6: period saturation in the calculator
      sat_alive = 6'd63; #1;
      check("sat_63", 32'(sat_period), 32'h00FFFFFF);
      sat_alive = 6'd1;  #1;
      check("sat_1",  32'(sat_period), 32'h00800004);
      sat_alive = 6'd2;  #1;
      check("sat_2",  32'(sat_period), 32'h00FFFFFF);
      sat_alive = 6'd0;  #1;
      check("sat_0",  32'(sat_period), 32'h00000004);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         RST    = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 99) < 97);
         r = $urandom_range(0, 99);
         if (r < 2)       alive_count = 6'd0;
         else if (r < 10) alive_count = 6'($urandom_range(1, 6));
         r = $urandom_range(0, 7);
         case (r)
            0: posx = 11'd9;
            1: posx = 11'd10;
            2: posx = 11'd11;
            3: posx = 11'd99;
            4: posx = 11'd100;
            5: posx = 11'd101;
            default: posx = 11'($urandom_range(0, 2047));
         endcase
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
